// File: rtl/axi_fifo_arb.sv
// -----------------------------------------------------------------------------
// axi_fifo_arb
//
// Round-robin packet arbiter that merges NUM_PORTS AXI-Stream style inputs
// into one stream feeding a shared FIFO. The arbiter picks a port while idle,
// then passes that port's whole packet through, one packet at a time. A new
// packet is started only when the FIFO reports at least MIN_SPACE free
// entries; once a packet has started, it runs to tlast regardless of space.
//
// Parameters
//   WIDTH      data width of every stream
//   NUM_PORTS  number of input streams (2..8)
//   MIN_SPACE  free FIFO entries required before a packet is granted
//
// Ports
//   clk        clock, all state on rising edge
//   reset      asynchronous active-low reset
//   clear      synchronous active-high flush of arbitration state
//   i_tdata    concatenated input data, port k at [WIDTH*k +: WIDTH]
//   i_tlast    per-port last
//   i_tvalid   per-port valid
//   i_tready   per-port ready (only the owning port sees o_tready)
//   o_tdata    merged output data
//   o_tlast    merged output last
//   o_tvalid   merged output valid
//   o_tready   ready from the shared FIFO
//   fifo_space free entries reported by the shared FIFO
//   grant      current / most recently granted port
//   active     high while a packet is in transfer
//   pkt_count  number of completed packets forwarded (wraps)
// -----------------------------------------------------------------------------
module axi_fifo_arb #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned MIN_SPACE = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic [WIDTH*NUM_PORTS-1:0] i_tdata,
  input  logic [NUM_PORTS-1:0]       i_tlast,
  input  logic [NUM_PORTS-1:0]       i_tvalid,
  output logic [NUM_PORTS-1:0]       i_tready,
  output logic [WIDTH-1:0]           o_tdata,
  output logic                       o_tlast,
  output logic                       o_tvalid,
  input  logic                       o_tready,
  input  logic [15:0]                fifo_space,
  output logic [2:0]                 grant,
  output logic                       active,
  output logic [15:0]                pkt_count
);

  // Port index of the last finished packet after reset/clear, so that the
  // search starting at last+1 lands on port 0 first.
  localparam logic [2:0] LastInit = 3'(NUM_PORTS - 1);

  typedef enum logic [0:0] {
    StIdle,
    StPass
  } state_e;

  state_e      r_state;
  logic [2:0]  r_last;
  logic [2:0]  r_grant;
  logic [15:0] r_pkt_count;

  // Arbitration search results
  logic        w_sel_found;
  logic [2:0]  w_sel_idx;
  int unsigned w_dist;
  int unsigned w_best_dist;

  logic        w_space_ok;
  logic        w_beat;
  logic        w_last_beat;

  // ---------------------------------------------------------------------------
  // Round-robin selection. Each requesting port is ranked by how far it sits
  // past the last winner (0 = immediately after it); the smallest rank wins.
  // Ranks are unique, so at most one port can win.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_dist      = 0;
    w_best_dist = NUM_PORTS;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_dist = (32'(k) + 2 * NUM_PORTS - 32'(r_last) - 1) % NUM_PORTS;
      if (i_tvalid[k] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        w_sel_idx   = 3'(k);
        w_sel_found = 1'b1;
      end
    end
  end

  assign w_space_ok = (fifo_space >= 16'(MIN_SPACE));

  // ---------------------------------------------------------------------------
  // Data path: while passing, the owning port is wired straight through to the
  // output and the FIFO's ready is steered back to that port only. While idle
  // everything is held low so no beat can slip through before the grant.
  // ---------------------------------------------------------------------------
  always_comb begin
    o_tdata  = '0;
    o_tlast  = 1'b0;
    o_tvalid = 1'b0;
    i_tready = '0;
    if (r_state == StPass) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (r_grant == 3'(k)) begin
          o_tdata     = i_tdata[WIDTH*k +: WIDTH];
          o_tlast     = i_tlast[k];
          o_tvalid    = i_tvalid[k];
          i_tready[k] = o_tready;
        end
      end
    end
  end

  assign w_beat      = o_tvalid && o_tready;
  assign w_last_beat = w_beat && o_tlast;

  // ---------------------------------------------------------------------------
  // Arbitration FSM. clear outranks everything, including a tlast beat in the
  // same cycle: the packet in flight is abandoned and not counted.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_last      <= LastInit;
      r_grant     <= '0;
      r_pkt_count <= '0;
    end else if (clear) begin
      r_state     <= StIdle;
      r_last      <= LastInit;
      r_grant     <= '0;
      r_pkt_count <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          // No space means no state change at all; the search simply repeats.
          if (w_sel_found && w_space_ok) begin
            r_grant <= w_sel_idx;
            r_state <= StPass;
          end
        end
        StPass: begin
          // Ownership persists until tlast moves; space is not re-checked.
          if (w_last_beat) begin
            r_state     <= StIdle;
            r_last      <= r_grant;
            r_pkt_count <= r_pkt_count + 16'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign grant     = r_grant;
  assign active    = (r_state == StPass);
  assign pkt_count = r_pkt_count;

endmodule
